// File: rtl/cherry_iq_pkg.sv
// Shared types and constants for the cherry instruction dispatch queue.
// The default channel map matches the control unit: DMA, math, cache, program end.
package cherry_iq_pkg;

  typedef enum logic [1:0] {
    CH_DMA      = 2'd0,
    CH_MATH     = 2'd1,
    CH_CACHE    = 2'd2,
    CH_PROG_END = 2'd3
  } iq_channel_e;

  localparam int IQ_PAYLOAD_W = 64;

  // Entry layout of the default build: channel index above the payload.
  typedef struct packed {
    iq_channel_e               typ;
    logic [IQ_PAYLOAD_W-1:0]   payload;
  } iq_entry_t;

  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_BAD_TYPE = 1;

endpackage

// File: rtl/iq_ring_buffer.sv
// Power-of-two ring buffer storing dispatch entries, with extended pointers
// whose extra MSB separates the full and empty cases after a wrap.
module iq_ring_buffer #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 66,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/iq_dispatch_queue.sv
// In-order dispatch queue: ring-buffer storage plus a registered one-hot issue stage
// that holds under freeze. Optional same-cycle bypass when storage is empty: IQ_BYPASS_EN.
module iq_dispatch_queue
  import cherry_iq_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int PAYLOAD_W    = 64,
  parameter  int NUM_CHANNELS = 4,
  parameter  int AFULL_MARGIN = 2,
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  // One bit above the channel index so out-of-range codes reach the bad-type check.
  localparam int TYPE_W       = CH_W + 1,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    freeze,
  input  logic                    we,
  input  logic [TYPE_W-1:0]       in_type,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  output logic                    stall_push,
  output logic [NUM_CHANNELS-1:0] out_valid,
  output logic [PAYLOAD_W-1:0]    out_payload,
  output logic                    empty,
  output logic [CNT_W-1:0]        count,
  output logic [1:0]              err
);

  localparam int ENTRY_W = CH_W + PAYLOAD_W;

  logic                    rb_push, rb_pop, rb_full, rb_empty;
  logic [CNT_W-1:0]        rb_count;
  logic [ENTRY_W-1:0]      rb_head;
  logic                    type_ok, adv, acc, byp;
  logic [NUM_CHANNELS-1:0] out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0]    out_payload_q, out_payload_d;
  logic [1:0]              err_q, err_d;

  function automatic logic [NUM_CHANNELS-1:0] to_onehot(input logic [CH_W-1:0] ch);
    return NUM_CHANNELS'(1) << ch;
  endfunction

  assign type_ok = (in_type < TYPE_W'(NUM_CHANNELS));
  assign adv     = !freeze;
  assign rb_pop  = adv && !rb_empty;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign acc     = we && type_ok && (!rb_full || rb_pop);

`ifdef IQ_BYPASS_EN
  assign byp = adv && rb_empty && acc;
`else
  assign byp = 1'b0;
`endif

  assign rb_push = acc && !byp;

  iq_ring_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ring (
    .clk   (clk),
    .reset (reset),
    .push  (rb_push),
    .pop   (rb_pop),
    .wdata ({in_type[CH_W-1:0], in_payload}),
    .rdata (rb_head),
    .full  (rb_full),
    .empty (rb_empty),
    .count (rb_count)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    if (adv) begin
      if (rb_pop) begin
        out_valid_d   = to_onehot(rb_head[ENTRY_W-1 -: CH_W]);
        out_payload_d = rb_head[PAYLOAD_W-1:0];
      end else if (byp) begin
        out_valid_d   = to_onehot(in_type[CH_W-1:0]);
        out_payload_d = in_payload;
      end else begin
        out_valid_d   = '0;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (we && !type_ok)        err_d[ERR_BAD_TYPE] = 1'b1;
    if (we && type_ok && !acc) err_d[ERR_OVERFLOW] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q   <= '0;
      out_payload_q <= '0;
      err_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_payload_q <= out_payload_d;
      err_q         <= err_d;
    end
  end

  assign stall_push  = (rb_count >= CNT_W'(DEPTH - AFULL_MARGIN));
  assign out_valid   = out_valid_q;
  assign out_payload = out_payload_q;
  assign empty       = rb_empty;
  assign count       = rb_count;
  assign err         = err_q;

endmodule
